// File: rtl/x_top_pkg.sv
// rtl/x_top_pkg.sv - shared widths, scan codes, op encodings and 7-seg helper for the keypad calculator
`ifndef DATA_W
`define DATA_W 32
`endif

package x_top_pkg;

  localparam int DATA_W      = `DATA_W;
  localparam int REGF_ADDR_W = 4;
  localparam int REGF_DEPTH  = 1 << REGF_ADDR_W;

  // regf word assignments
  localparam int R_ACC  = 0;
  localparam int R_OPD  = 1;
  localparam int R_OP   = 2;
  localparam int R_CODE = 3;
  localparam int R_CNT  = 4;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ADD   = 8'h79;
  localparam logic [7:0] SC_SUB   = 8'h7B;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  localparam logic signed [DATA_W-1:0] ACC_MAX = 999;
  localparam logic signed [DATA_W-1:0] ACC_MIN = -999;

  // active-low {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } op_e;

  typedef enum logic [2:0] {
    KEY_NONE,
    KEY_DIGIT,
    KEY_ADD,
    KEY_SUB,
    KEY_ENTER
  } key_e;

  typedef struct packed {
    key_e       kind;
    logic [3:0] digit;
  } key_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  function automatic key_t decode_key(input logic [7:0] code);
    key_t k;
    k.kind  = KEY_DIGIT;
    k.digit = 4'd0;
    case (code)
      8'h70:    k.digit = 4'd0;
      8'h69:    k.digit = 4'd1;
      8'h72:    k.digit = 4'd2;
      8'h7A:    k.digit = 4'd3;
      8'h6B:    k.digit = 4'd4;
      8'h73:    k.digit = 4'd5;
      8'h74:    k.digit = 4'd6;
      8'h6C:    k.digit = 4'd7;
      8'h75:    k.digit = 4'd8;
      8'h7D:    k.digit = 4'd9;
      SC_ADD:   k.kind  = KEY_ADD;
      SC_SUB:   k.kind  = KEY_SUB;
      SC_ENTER: k.kind  = KEY_ENTER;
      default:  k.kind  = KEY_NONE;
    endcase
    return k;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/x_top_if.sv
// rtl/x_top_if.sv - PS/2 keyboard line bundle (clock + data)
interface x_top_if;
  logic ps2_clk;
  logic ps2_data;

  // keyboard side drives the lines, receiver only observes them
  modport master (output ps2_clk, output ps2_data);
  modport slave  (input  ps2_clk, input  ps2_data);
endinterface

// File: rtl/x_top_ps2_rx.sv
// rtl/x_top_ps2_rx.sv - PS/2 frame receiver with line sync, falling-edge sampling and mid-frame timeout
module x_top_ps2_rx
  import x_top_pkg::*;
#(
  parameter int PS2_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  x_top_if.slave     ps2_i,
  output logic [7:0] tdata_o,
  output logic       tvalid_o
);

  localparam int TO_W = $clog2(PS2_TIMEOUT + 1);

  // [1] is the synced clock, [2] its previous value for edge detection
  logic [2:0]      clk_sync_q;
  logic [1:0]      data_sync_q;
  rx_state_e       state_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic [TO_W-1:0] idle_cnt_q;
  logic [7:0]      code_q;
  logic            valid_q;
  logic            fall;

  assign fall     = clk_sync_q[2] & ~clk_sync_q[1];
  assign tdata_o  = code_q;
  assign tvalid_o = valid_q;

  // two-flop synchronisers on both asynchronous PS/2 lines
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_i.ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_i.ps2_data};
    end
  end

  // frame FSM: one bit per falling edge, a stalled partial frame is abandoned
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RX_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      idle_cnt_q <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (fall) begin
        idle_cnt_q <= '0;
      end else if (state_q != RX_IDLE) begin
        idle_cnt_q <= idle_cnt_q + TO_W'(1);
      end
      if (fall) begin
        case (state_q)
          RX_IDLE: begin
            // a high start bit is noise; keep waiting
            if (!data_sync_q[1]) begin
              state_q   <= RX_DATA;
              bit_cnt_q <= '0;
            end
          end
          RX_DATA: begin
            shift_q   <= {data_sync_q[1], shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
          end
          RX_PARITY: state_q <= RX_STOP;
          RX_STOP: begin
            state_q <= RX_IDLE;
            if (data_sync_q[1]) begin
              code_q  <= shift_q;
              valid_q <= 1'b1;
            end
          end
          default: state_q <= RX_IDLE;
        endcase
      end else if (state_q != RX_IDLE && idle_cnt_q == TO_W'(PS2_TIMEOUT - 1)) begin
        state_q   <= RX_IDLE;
        bit_cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/x_top_regf.sv
// rtl/x_top_regf.sv - 16-word calculator state register file with per-word write enables
module x_top_regf
  import x_top_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic [REGF_DEPTH-1:0]               we_i,
  input  logic [REGF_DEPTH-1:0][DATA_W-1:0]   wdata_i,
  output logic [REGF_DEPTH-1:0][DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] reg_1 [REGF_DEPTH];

  // several words may change in the same cycle (e.g. Enter clears three)
  always_ff @(posedge clk) begin
    for (int i = 0; i < REGF_DEPTH; i++) begin
      if (rst) begin
        reg_1[i] <= '0;
      end else if (we_i[i]) begin
        reg_1[i] <= wdata_i[i];
      end
    end
  end

  // flat read view of every word
  always_comb begin
    for (int i = 0; i < REGF_DEPTH; i++) begin
      rdata_o[i] = reg_1[i];
    end
  end

endmodule

// File: rtl/x_top.sv
// rtl/x_top.sv - keypad calculator top: PS/2 in, saturating signed accumulator, 4-digit 7-seg out
module x_top
  import x_top_pkg::*;
#(
  parameter int PS2_TIMEOUT = 100000,
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_data,
  input  logic        ps2_clk,
  input  logic        push_AC,
  input  logic        push_C,
  output logic [11:0] disp_ctrl,
  output logic [7:0]  gpo_out
);

  localparam int REF_W = $clog2(REFRESH_DIV + 1);

  x_top_if u_ps2_if ();
  assign u_ps2_if.ps2_clk  = ps2_clk;
  assign u_ps2_if.ps2_data = ps2_data;

  logic [7:0] code;
  logic       code_valid;

  x_top_ps2_rx #(.PS2_TIMEOUT(PS2_TIMEOUT)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .ps2_i    (u_ps2_if),
    .tdata_o  (code),
    .tvalid_o (code_valid)
  );

  logic [REGF_DEPTH-1:0]             we;
  logic [REGF_DEPTH-1:0][DATA_W-1:0] wdata;
  logic [REGF_DEPTH-1:0][DATA_W-1:0] rdata;

  x_top_regf u_regf (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  logic signed [DATA_W-1:0] acc, sum, sat;
  logic [DATA_W-1:0]        opd, cnt;
  op_e                      op;
  key_t                     key;
  logic                     key_act;
  logic                     brk_q, brk_d;

  assign acc = $signed(rdata[R_ACC]);
  assign opd = rdata[R_OPD];
  assign cnt = rdata[R_CNT];
  assign op  = op_e'(rdata[R_OP][1:0]);

  // break-prefix tracking; a key only acts when it is a make code
  always_comb begin
    key     = decode_key(code);
    brk_d   = brk_q;
    key_act = 1'b0;
    if (code_valid) begin
      if (brk_q) begin
        brk_d = 1'b0;
      end else if (code == SC_BREAK) begin
        brk_d = 1'b1;
      end else begin
        key_act = (key.kind != KEY_NONE);
      end
    end
  end

  // break flag register
  always_ff @(posedge clk) begin
    if (rst) brk_q <= 1'b0;
    else     brk_q <= brk_d;
  end

  // Enter result, clamped to what three digits plus sign can show
  always_comb begin
    case (op)
      OP_ADD:  sum = acc + $signed(opd);
      OP_SUB:  sum = acc - $signed(opd);
      default: sum = $signed(opd);
    endcase
    if (sum > ACC_MAX)      sat = ACC_MAX;
    else if (sum < ACC_MIN) sat = ACC_MIN;
    else                    sat = sum;
  end

  // calculator next state; buttons override a coincident key
  always_comb begin
    we    = '0;
    wdata = '0;
    if (push_AC) begin
      we[R_ACC] = 1'b1;
      we[R_OPD] = 1'b1;
      we[R_OP]  = 1'b1;
      we[R_CNT] = 1'b1;
    end else if (push_C) begin
      we[R_OPD] = 1'b1;
      we[R_CNT] = 1'b1;
    end else if (key_act) begin
      we[R_CODE]    = 1'b1;
      wdata[R_CODE] = DATA_W'(code);
      case (key.kind)
        KEY_DIGIT: begin
          if (cnt < DATA_W'(3)) begin
            we[R_OPD]    = 1'b1;
            wdata[R_OPD] = opd * DATA_W'(10) + DATA_W'(key.digit);
            we[R_CNT]    = 1'b1;
            wdata[R_CNT] = cnt + DATA_W'(1);
          end
        end
        KEY_ADD: begin
          we[R_OP]    = 1'b1;
          wdata[R_OP] = DATA_W'(OP_ADD);
        end
        KEY_SUB: begin
          we[R_OP]    = 1'b1;
          wdata[R_OP] = DATA_W'(OP_SUB);
        end
        KEY_ENTER: begin
          we[R_ACC]    = 1'b1;
          wdata[R_ACC] = sat;
          we[R_OPD]    = 1'b1;
          we[R_OP]     = 1'b1;
          we[R_CNT]    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic signed [DATA_W-1:0] shown;
  logic [DATA_W-1:0]        mag_w;
  logic [9:0]               mag;
  logic                     neg;
  logic [3:0]               d_hund, d_tens, d_unit;

  // pick the value on display and split it into decimal digits
  always_comb begin
    shown  = (cnt != '0) ? $signed(opd) : acc;
    neg    = shown[DATA_W-1];
    mag_w  = neg ? -shown : shown;
    mag    = mag_w[9:0];
    d_hund = 4'(mag / 10'd100);
    d_tens = 4'((mag / 10'd10) % 10'd10);
    d_unit = 4'(mag % 10'd10);
  end

  logic [REF_W-1:0] ref_cnt_q;
  logic [1:0]       slot_q;

  // advance the active digit every REFRESH_DIV cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_q <= '0;
      slot_q    <= '0;
    end else if (ref_cnt_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_cnt_q <= '0;
      slot_q    <= slot_q + 2'd1;
    end else begin
      ref_cnt_q <= ref_cnt_q + REF_W'(1);
    end
  end

  logic [7:0] seg;
  logic [3:0] anode;

  // segment pattern for the active slot, leading zeros blanked
  always_comb begin
    case (slot_q)
      2'd0:    seg = seg7(d_unit);
      2'd1:    seg = (d_hund != 4'd0 || d_tens != 4'd0) ? seg7(d_tens) : SEG_BLANK;
      2'd2:    seg = (d_hund != 4'd0) ? seg7(d_hund) : SEG_BLANK;
      default: seg = neg ? SEG_MINUS : SEG_BLANK;
    endcase
    anode = ~(4'b0001 << slot_q);
  end

  assign disp_ctrl = rst ? 12'hFFF : {anode, seg};
  assign gpo_out   = rst ? 8'h00 : rdata[R_ACC][7:0];

  logic unused_bits;
  assign unused_bits = ^{rdata[R_CODE], rdata[R_OP][DATA_W-1:2], mag_w[DATA_W-1:10],
                         rdata[REGF_DEPTH-1:5]};

endmodule

// File: tb/tb_x_top.sv
// tb/tb_x_top.sv - randomized bench for x_top against a behavioural calculator model
module tb_x_top;

  localparam int TO   = 200;
  localparam int RDIV = 16;
  localparam int HALF = 5;
  localparam logic [7:0] DIG_CODES [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                            8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
  localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push_AC = 1'b0;
  logic        push_C = 1'b0;
  logic [11:0] disp_ctrl;
  logic [7:0]  gpo_out;

  x_top_if kbd ();

  always #10 clk = ~clk;

  x_top #(.PS2_TIMEOUT(TO), .REFRESH_DIV(RDIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_data  (kbd.ps2_data),
    .ps2_clk   (kbd.ps2_clk),
    .push_AC   (push_AC),
    .push_C    (push_C),
    .disp_ctrl (disp_ctrl),
    .gpo_out   (gpo_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  int m_acc, m_opd, m_op, m_cnt, m_last;
  bit m_brk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int digit_of(input logic [7:0] c);
    for (int i = 0; i < 10; i++) if (DIG_CODES[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_opd = 0; m_op = 0; m_cnt = 0; m_last = 0; m_brk = 0;
  endtask

  task automatic model_code(input logic [7:0] c, input bit drop);
    int d;
    if (m_brk) begin
      m_brk = 0;
      return;
    end
    if (c == 8'hF0) begin
      m_brk = 1;
      return;
    end
    d = digit_of(c);
    if (drop) return;
    if (d >= 0) begin
      m_last = c;
      if (m_cnt < 3) begin
        m_opd = m_opd * 10 + d;
        m_cnt++;
      end
    end else if (c == 8'h79) begin
      m_last = c; m_op = 1;
    end else if (c == 8'h7B) begin
      m_last = c; m_op = 2;
    end else if (c == 8'h5A) begin
      m_last = c;
      if (m_op == 1)      m_acc = m_acc + m_opd;
      else if (m_op == 2) m_acc = m_acc - m_opd;
      else                m_acc = m_opd;
      if (m_acc > 999)  m_acc = 999;
      if (m_acc < -999) m_acc = -999;
      m_opd = 0; m_op = 0; m_cnt = 0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    kbd.ps2_data = b;
    repeat (HALF) @(negedge clk);
    kbd.ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    kbd.ps2_clk = 1'b1;
  endtask

  task automatic send_raw(input logic [7:0] c, input int nbits);
    logic [10:0] f;
    f = {1'b1, 1'b1, c, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic key(input logic [7:0] c);
    send_raw(c, 11);
    model_code(c, 1'b0);
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, " r0"}, dut.u_regf.reg_1[0], 32'(m_acc));
    check_eq({tag, " r1"}, dut.u_regf.reg_1[1], 32'(m_opd));
    check_eq({tag, " r2"}, dut.u_regf.reg_1[2], 32'(m_op));
    check_eq({tag, " r3"}, dut.u_regf.reg_1[3], 32'(m_last));
    check_eq({tag, " r4"}, dut.u_regf.reg_1[4], 32'(m_cnt));
    check_eq({tag, " gpo"}, {24'd0, gpo_out}, 32'(m_acc & 255));
  endtask

  task automatic press(input logic [7:0] c);
    key(c);
    check_regs($sformatf("make %h", c));
    key(8'hF0);
    key(c);
  endtask

  task automatic pulse_c();
    push_C = 1'b1;
    @(negedge clk);
    push_C = 1'b0;
    m_opd = 0; m_cnt = 0;
  endtask

  task automatic pulse_ac();
    push_AC = 1'b1;
    @(negedge clk);
    push_AC = 1'b0;
    m_acc = 0; m_opd = 0; m_op = 0; m_cnt = 0;
  endtask

  task automatic check_display(input string tag);
    int v, mag, bad;
    logic [7:0] exp_seg [4];
    logic [7:0] seen [4];
    v   = (m_cnt > 0) ? m_opd : m_acc;
    mag = (v < 0) ? -v : v;
    exp_seg[0] = SEG_TAB[mag % 10];
    exp_seg[1] = (mag >= 10)  ? SEG_TAB[(mag / 10) % 10] : 8'hFF;
    exp_seg[2] = (mag >= 100) ? SEG_TAB[mag / 100] : 8'hFF;
    exp_seg[3] = (v < 0) ? 8'hBF : 8'hFF;
    for (int k = 0; k < 4; k++) seen[k] = 8'h00;
    bad = 0;
    repeat (4 * RDIV + 2) begin
      @(negedge clk);
      case (disp_ctrl[11:8])
        4'b1110: seen[0] = disp_ctrl[7:0];
        4'b1101: seen[1] = disp_ctrl[7:0];
        4'b1011: seen[2] = disp_ctrl[7:0];
        4'b0111: seen[3] = disp_ctrl[7:0];
        default: bad++;
      endcase
    end
    check_eq({tag, " anodes"}, 32'(bad), 32'd0);
    for (int k = 0; k < 4; k++)
      check_eq($sformatf("%s dig%0d", tag, k), {24'd0, seen[k]}, {24'd0, exp_seg[k]});
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, " disp"}, {20'd0, disp_ctrl}, 32'hFFF);
    check_eq({tag, " gpo"}, {24'd0, gpo_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++)
      check_eq($sformatf("%s reg%0d", tag, i), dut.u_regf.reg_1[i], 32'd0);
  endtask

  initial begin
    logic [7:0] c;
    int r;
    bit hit;
    kbd.ps2_clk  = 1'b1;
    kbd.ps2_data = 1'b1;
    model_reset();

    do_reset("c1");
    check_display("c1");

    key(8'h79); key(8'hF0); key(8'h79);
    key(8'h69); key(8'hF0); key(8'h69);
    key(8'h74); key(8'hF0); key(8'h74);
    key(8'h5A); key(8'hF0); key(8'h5A);
    check_regs("c2");
    check_eq("c2 r0 const", dut.u_regf.reg_1[0], 32'd16);

    press(8'h7B); press(8'h5A); press(8'h7B); press(8'h75); press(8'h7D);
    check_regs("c3a");
    check_eq("c3 r1 const", dut.u_regf.reg_1[1], 32'd89);
    check_display("c3a");
    press(8'h5A);
    check_eq("c3 r0 const", dut.u_regf.reg_1[0], 32'hFFFF_FFB7);
    check_display("c3b");

    repeat (4) press(8'h7D);
    check_eq("c4 r1 const", dut.u_regf.reg_1[1], 32'd999);
    check_eq("c4 r4 const", dut.u_regf.reg_1[4], 32'd3);
    press(8'h5A);
    press(8'h79);
    repeat (3) press(8'h7D);
    press(8'h5A);
    check_regs("c4");
    check_eq("c4 sat hi", dut.u_regf.reg_1[0], 32'd999);
    pulse_ac();
    check_regs("c4 ac");
    press(8'h7B); repeat (3) press(8'h7D); press(8'h5A);
    press(8'h7B); repeat (3) press(8'h7D); press(8'h5A);
    check_eq("c4 sat lo", dut.u_regf.reg_1[0], 32'hFFFF_FC19);
    check_display("c4 neg");
    pulse_ac();

    send_raw(8'h7A, 6);
    repeat (TO + 50) @(negedge clk);
    key(8'h69);
    check_regs("c5");
    check_eq("c5 r3 const", dut.u_regf.reg_1[3], 32'h69);
    key(8'hF0); key(8'h69);

    hit = 1'b0;
    fork
      send_raw(8'h72, 11);
      begin
        for (int i = 0; i < 300 && !hit; i++) begin
          @(negedge clk);
          if (dut.code_valid) begin
            push_C = 1'b1;
            hit = 1'b1;
            @(negedge clk);
            push_C = 1'b0;
          end
        end
      end
    join
    check_eq("c6 valid seen", {31'd0, hit}, 32'd1);
    model_code(8'h72, 1'b1);
    m_opd = 0; m_cnt = 0;
    check_regs("c6");
    key(8'hF0); key(8'h72);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 19);
      if (r < 10)      c = DIG_CODES[$urandom_range(0, 9)];
      else if (r < 12) c = 8'h79;
      else if (r < 14) c = 8'h7B;
      else if (r < 17) c = 8'h5A;
      else if (r < 18) c = 8'hE0;
      else             c = 8'($urandom);
      press(c);
      check_regs($sformatf("rnd %0d", n));
      if ($urandom_range(0, 9) == 0) begin
        pulse_c();
        check_regs("rnd C");
      end
      if ($urandom_range(0, 19) == 0) begin
        pulse_ac();
        check_regs("rnd AC");
      end
      if (n % 8 == 7) check_display($sformatf("rnd %0d", n));
    end

    do_reset("final");
    check_display("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
